// File: rtl/noc_gate_pkg.sv
// rtl/noc_gate_pkg.sv - shared gate state type and sizing helpers for boundary gates
package noc_gate_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } gate_state_t;

  // Number of link flits needed to carry one boundary word.
  function automatic int flits(input int data_width, input int link_width);
    return data_width / link_width;
  endfunction

  // Flit counter width; a single-flit word still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_gate_serializer.sv
// rtl/tx_gate_serializer.sv - per-gate boundary word serializer onto a valid/ready flit link
module tx_gate_serializer
  import noc_gate_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINK_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_gen_sync,
  input  logic                  i_tx_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_tx_ready,
  output logic [LINK_WIDTH-1:0] o_link_data,
  output logic                  o_link_valid,
  output logic                  o_link_last,
  input  logic                  i_link_ready,
  output logic                  o_overrun
);

  localparam int FLITS = flits(DATA_WIDTH, LINK_WIDTH);
  localparam int CW    = cnt_width(FLITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(FLITS - 1);

  if ((DATA_WIDTH % LINK_WIDTH) != 0) begin : g_bad_width
    $error("tx_gate_serializer: DATA_WIDTH must be an integer multiple of LINK_WIDTH");
  end

  gate_state_t           state;
  logic [CW-1:0]         cnt;
  // Holds the flits not yet presented; the current flit lives in o_link_data.
  logic [DATA_WIDTH-1:0] shreg;

  // Gate FSM: latch on start, step one flit per handshake, sync/reset abort to idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      o_link_data  <= '0;
      o_link_valid <= 1'b0;
      o_link_last  <= 1'b0;
      o_tx_ready   <= 1'b1;
      o_overrun    <= 1'b0;
    end else if (i_gen_sync) begin
      state        <= IDLE;
      cnt          <= '0;
      o_link_valid <= 1'b0;
      o_link_last  <= 1'b0;
      o_tx_ready   <= 1'b1;
      o_overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_tx_start) begin
            state        <= SEND;
            cnt          <= '0;
            shreg        <= i_data >> LINK_WIDTH;
            o_link_data  <= i_data[LINK_WIDTH-1:0];
            o_link_valid <= 1'b1;
            o_link_last  <= (FLITS == 1);
            o_tx_ready   <= 1'b0;
          end
        end
        SEND: begin
          // A start while busy is dropped but remembered until the next sync.
          if (i_tx_start) begin
            o_overrun <= 1'b1;
          end
          if (i_link_ready) begin
            if (cnt == LAST_IDX) begin
              state        <= IDLE;
              cnt          <= '0;
              o_link_valid <= 1'b0;
              o_link_last  <= 1'b0;
              o_tx_ready   <= 1'b1;
            end else begin
              cnt         <= cnt + CW'(1);
              shreg       <= shreg >> LINK_WIDTH;
              o_link_data <= shreg[LINK_WIDTH-1:0];
              o_link_last <= ((cnt + CW'(1)) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_gate_serializer.sv
// tb/tb_tx_gate_serializer.sv - self-checking bench for tx_gate_serializer (32-bit word, 8-bit link)
module tb_tx_gate_serializer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_gen_sync;
  logic        i_tx_start;
  logic [31:0] i_data;
  logic        o_tx_ready;
  logic [7:0]  o_link_data;
  logic        o_link_valid;
  logic        o_link_last;
  logic        i_link_ready;
  logic        o_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_ovr = 1'b0;

  tx_gate_serializer #(.DATA_WIDTH(32), .LINK_WIDTH(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_gen_sync   (i_gen_sync),
    .i_tx_start   (i_tx_start),
    .i_data       (i_data),
    .o_tx_ready   (o_tx_ready),
    .o_link_data  (o_link_data),
    .o_link_valid (o_link_valid),
    .o_link_last  (o_link_last),
    .i_link_ready (i_link_ready),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, o_link_valid, 1'b0);
    chk({tag, "_last"}, o_link_last, 1'b0);
    chk({tag, "_ready"}, o_tx_ready, 1'b1);
    chk({tag, "_ovr"}, o_overrun, exp_ovr);
  endtask

  // Called at a falling edge; the start is sampled on the following rising edge.
  task automatic start_word(input logic [31:0] w);
    i_tx_start = 1'b1;
    i_data     = w;
    @(negedge i_clk);
    i_tx_start = 1'b0;
    i_data     = $urandom;
  endtask

  // Reference: flit k of word w is bits [8k+7:8k]; last only on flit 3; the gate
  // frees up after 4 handshakes plus however many cycles the link stalled.
  // mode 0: link always ready, 1: stall_len cycles on flit stall_flit, 2: random ready.
  task automatic stream(input logic [31:0] w, input int mode, input int stall_flit,
                        input int stall_len, input int inj_at, input int nflits);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    logic r;
    while (k < nflits && cyc < 200) begin
      chk("flit_valid", o_link_valid, 1'b1);
      chk("flit_data", o_link_data, (w >> (8 * k)) & 32'hFF);
      chk("flit_last", o_link_last, (k == 3));
      chk("busy_ready", o_tx_ready, 1'b0);
      chk("busy_ovr", o_overrun, exp_ovr);
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (k == stall_flit && stalls < stall_len) ? 1'b0 : 1'b1;
      else r = 1'($urandom_range(0, 1));
      if (!r) stalls++;
      i_link_ready = r;
      if (cyc == inj_at) begin
        i_tx_start = 1'b1;
        i_data     = 32'hFFFF_FFFF;
      end
      @(negedge i_clk);
      if (cyc == inj_at) begin
        i_tx_start = 1'b0;
        exp_ovr    = 1'b1;
      end
      cyc++;
      if (r) k++;
    end
    i_link_ready = 1'b0;
    chk("stream_timeout", (cyc < 200), 1'b1);
    if (nflits == 4) begin
      chk("done_cycles", cyc, 4 + stalls);
      chk_idle("done");
    end
  endtask

  task automatic sync_pulse();
    i_gen_sync = 1'b1;
    @(negedge i_clk);
    i_gen_sync = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    i_rst_n = 1'b0;
    i_gen_sync = 1'b0;
    i_tx_start = 1'b0;
    i_data = '0;
    i_link_ready = 1'b0;

    // Reset held for 3 cycles, then idle for 10 cycles.
    repeat (3) @(negedge i_clk);
    chk_idle("reset");
    chk("reset_data", o_link_data, 8'h00);
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk_idle("idle");
    end

    // Basic serialize with link always ready.
    start_word(32'hA1B2_C3D4);
    stream(32'hA1B2_C3D4, 0, 0, 0, -1, 4);

    // Backpressure: 3 stall cycles on the second flit.
    start_word(32'hA1B2_C3D4);
    stream(32'hA1B2_C3D4, 1, 1, 3, -1, 4);

    // Overrun: second start during SEND leaves the stream intact and sets the flag.
    w = $urandom;
    start_word(w);
    stream(w, 0, 0, 0, 1, 4);
    repeat (2) begin
      @(negedge i_clk);
      chk_idle("ovr_hold");
    end
    sync_pulse();
    chk_idle("ovr_clear");

    // Sync abort after two flits, then a fresh word starts from its low flit.
    start_word(32'h1122_3344);
    stream(32'h1122_3344, 0, 0, 0, -1, 2);
    sync_pulse();
    chk_idle("abort");
    start_word(32'h5566_7788);
    stream(32'h5566_7788, 0, 0, 0, -1, 4);

    // Mid-transfer synchronous reset.
    w = $urandom;
    start_word(w);
    stream(w, 0, 0, 0, 0, 2);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_ovr = 1'b0;
    chk_idle("midreset");
    chk("midreset_data", o_link_data, 8'h00);

    // Sync and start together: sync wins, nothing starts, no overrun.
    i_gen_sync = 1'b1;
    i_tx_start = 1'b1;
    i_data = 32'hDEAD_BEEF;
    @(negedge i_clk);
    i_gen_sync = 1'b0;
    i_tx_start = 1'b0;
    chk_idle("syncstart");
    @(negedge i_clk);
    chk_idle("syncstart_after");

    // Sync and start together while busy: transfer aborted, overrun stays clear.
    w = $urandom;
    start_word(w);
    stream(w, 0, 0, 0, -1, 1);
    i_gen_sync = 1'b1;
    i_tx_start = 1'b1;
    @(negedge i_clk);
    i_gen_sync = 1'b0;
    i_tx_start = 1'b0;
    chk_idle("busy_syncstart");

    // Random words under random backpressure, occasionally with an overrun.
    for (int n = 0; n < 20; n++) begin
      w = $urandom;
      start_word(w);
      stream(w, 2, 0, 0, ($urandom_range(0, 3) == 0) ? 2 : -1, 4);
      repeat ($urandom_range(0, 2)) begin
        @(negedge i_clk);
        chk_idle("rand_gap");
      end
      if (exp_ovr) sync_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
